sync_frame_fifo: RTL and testbench

//   Single-clock frame FIFO with commit/drop semantics for store-and-forward switch ports.

---
 rtl/sync_frame_fifo.sv | 108 ++++++++++
 tb/tb_sync_frame_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO: words are written speculatively and become readable only
// once their frame is committed; dropped or overflowed frames are reclaimed in one cycle.
module sync_frame_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    input  logic                  wr_drop,
    output logic                  full,
    output logic                  afull,
    output logic                  frame_dropped,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_occu,
    output logic [ADDR_WIDTH:0]   rd_avail
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] cptr;
    logic [PW-1:0] rptr;
    logic          ovf;

    logic          do_write;
    logic          write_lost;
    logic          ovf_now;
    logic          do_commit;
    logic          do_drop;
    logic          do_read;
    logic [PW-1:0] wptr_adv;

    // Pointer differences wrap modulo 2^PW, so the extra MSB separates full from empty.
    assign fifo_occu = wptr - rptr;
    assign rd_avail  = cptr - rptr;
    assign full      = (fifo_occu == PW'(DEPTH));
    assign empty     = (rd_avail == '0);
    assign afull     = (fifo_occu >= PW'(AFULL_THRESH));

    // A word lost in this very cycle already marks the frame as corrupt.
    always_comb begin
        do_write   = wr_en && !full;
        write_lost = wr_en && full;
        ovf_now    = ovf || write_lost;
        do_drop    = wr_drop || (wr_commit && ovf_now);
        do_commit  = wr_commit && !wr_drop && !ovf_now;
        do_read    = rd_en && !empty;
        wptr_adv   = do_write ? (wptr + PW'(1)) : wptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr          <= '0;
            cptr          <= '0;
            rptr          <= '0;
            ovf           <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= do_drop;
            if (do_drop) begin
                wptr <= cptr;
            end else begin
                wptr <= wptr_adv;
            end
            if (do_commit) begin
                cptr <= wptr_adv;
            end
            if (do_commit || do_drop) begin
                ovf <= 1'b0;
            end else if (write_lost) begin
                ovf <= 1'b1;
            end
            if (do_read) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            ram[wptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // rd_data holds its last value when no read is performed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_read;
            if (do_read) begin
                rd_data <= ram[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Directed bench for sync_frame_fifo: commit, drop, overflow, wrap, same-cycle
// interactions and mid-frame reset, each against hand-computed values.
module tb_sync_frame_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_commit;
    logic       wr_drop;
    logic       full;
    logic       afull;
    logic       frame_dropped;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic [4:0] fifo_occu;
    logic [4:0] rd_avail;

    int total = 0;
    int bad   = 0;

    sync_frame_fifo #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (4),
        .AFULL_THRESH (14)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_commit     (wr_commit),
        .wr_drop       (wr_drop),
        .full          (full),
        .afull         (afull),
        .frame_dropped (frame_dropped),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .fifo_occu     (fifo_occu),
        .rd_avail      (rd_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge, so outputs are sampled settled.
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic wc,
                                 input logic wdp, input logic re);
        wr_en     = we;
        wr_data   = wd;
        wr_commit = wc;
        wr_drop   = wdp;
        rd_en     = re;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        wr_commit = 1'b0;
        wr_drop   = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] d;

        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        wr_commit = 1'b0;
        wr_drop   = 1'b0;
        rd_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_occu", 32'(fifo_occu), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h00);
        checkOutput("reset_dropped", 32'(frame_dropped), 32'd0);
        reset = 1'b0;

        $display("[TB] basic commit and read");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_uncommitted_avail", 32'(rd_avail), 32'd0);
        checkOutput("t1_uncommitted_empty", 32'(empty), 32'd1);
        checkOutput("t1_occu1", 32'(fifo_occu), 32'd1);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_avail3", 32'(rd_avail), 32'd3);
        checkOutput("t1_not_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid0", 32'(rd_valid), 32'd1);
        checkOutput("t1_data0", 32'(rd_data), 32'hA1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid1", 32'(rd_valid), 32'd1);
        checkOutput("t1_data1", 32'(rd_data), 32'hA2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid2", 32'(rd_valid), 32'd1);
        checkOutput("t1_data2", 32'(rd_data), 32'hA3);
        checkOutput("t1_empty_after", 32'(empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_valid_low", 32'(rd_valid), 32'd0);
        checkOutput("t1_data_hold", 32'(rd_data), 32'hA3);

        $display("[TB] drop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
            checkOutput("t2_empty_during", 32'(empty), 32'd1);
        end
        checkOutput("t2_occu5", 32'(fifo_occu), 32'd5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_dropped", 32'(frame_dropped), 32'd1);
        checkOutput("t2_occu0", 32'(fifo_occu), 32'd0);
        checkOutput("t2_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_dropped_pulse", 32'(frame_dropped), 32'd0);
        checkOutput("t2_rd_empty_valid", 32'(rd_valid), 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
            if (i == 12) checkOutput("t3_afull_13", 32'(afull), 32'd0);
            if (i == 13) checkOutput("t3_afull_14", 32'(afull), 32'd1);
            if (i == 14) checkOutput("t3_full_15", 32'(full), 32'd0);
        end
        checkOutput("t3_full_16", 32'(full), 32'd1);
        checkOutput("t3_occu16", 32'(fifo_occu), 32'd16);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_occu_after_lost", 32'(fifo_occu), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_ovf_dropped", 32'(frame_dropped), 32'd1);
        checkOutput("t3_ovf_occu", 32'(fifo_occu), 32'd0);
        checkOutput("t3_ovf_avail", 32'(rd_avail), 32'd0);
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_next_dropped", 32'(frame_dropped), 32'd0);
        checkOutput("t3_next_avail", 32'(rd_avail), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_next_data0", 32'(rd_data), 32'hC1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_next_data1", 32'(rd_data), 32'hC2);
        checkOutput("t3_next_valid", 32'(rd_valid), 32'd1);

        $display("[TB] wrap");
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 7; i++) begin
                d = 8'((f << 4) | i);
                applyStimulus(1'b1, d, (i == 6), 1'b0, 1'b0);
            end
            checkOutput("t4_avail7", 32'(rd_avail), 32'd7);
            for (int i = 0; i < 7; i++) begin
                d = 8'((f << 4) | i);
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
                checkOutput("t4_data", 32'(rd_data), 32'(d));
                checkOutput("t4_valid", 32'(rd_valid), 32'd1);
            end
            checkOutput("t4_occu0", 32'(fifo_occu), 32'd0);
        end

        $display("[TB] simultaneous operations");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + i), (i == 15), 1'b0, 1'b0);
            if (i == 14) checkOutput("t5_occu15", 32'(fifo_occu), 32'd15);
        end
        checkOutput("t5_occu16", 32'(fifo_occu), 32'd16);
        checkOutput("t5_avail16", 32'(rd_avail), 32'd16);
        checkOutput("t5_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_rw_valid", 32'(rd_valid), 32'd1);
        checkOutput("t5_rw_data", 32'(rd_data), 32'h30);
        checkOutput("t5_rw_occu", 32'(fifo_occu), 32'd15);
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_refill_occu", 32'(fifo_occu), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_ovf_commit_dropped", 32'(frame_dropped), 32'd1);
        checkOutput("t5_ovf_commit_occu", 32'(fifo_occu), 32'd15);
        checkOutput("t5_ovf_commit_avail", 32'(rd_avail), 32'd15);
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_drop_wins_dropped", 32'(frame_dropped), 32'd1);
        checkOutput("t5_drop_wins_occu", 32'(fifo_occu), 32'd15);
        checkOutput("t5_drop_wins_avail", 32'(rd_avail), 32'd15);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            checkOutput("t5_drain_data", 32'(rd_data), 32'(8'h30 + i));
        end
        checkOutput("t5_drained_empty", 32'(empty), 32'd1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_commit_read_valid", 32'(rd_valid), 32'd0);
        checkOutput("t5_commit_read_avail", 32'(rd_avail), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_late_read_valid", 32'(rd_valid), 32'd1);
        checkOutput("t5_late_read_data", 32'(rd_data), 32'h77);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_pre_data", 32'(rd_data), 32'h61);
        checkOutput("t6_pre_occu", 32'(fifo_occu), 32'd2);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h64;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        checkOutput("t6_occu", 32'(fifo_occu), 32'd0);
        checkOutput("t6_avail", 32'(rd_avail), 32'd0);
        checkOutput("t6_empty", 32'(empty), 32'd1);
        checkOutput("t6_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("t6_rd_data", 32'(rd_data), 32'h00);
        checkOutput("t6_dropped", 32'(frame_dropped), 32'd0);
        applyStimulus(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h72, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_new_avail", 32'(rd_avail), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_new_data0", 32'(rd_data), 32'h71);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_new_data1", 32'(rd_data), 32'h72);
        checkOutput("t6_new_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
